// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues single-beat AXI reads from code RAM, buffers
// returned words with their PCs, and handles redirects and bus errors.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  s_cram_arid,
   output logic [31:0] s_cram_araddr,
   output logic [7:0]  s_cram_arlen,
   output logic [2:0]  s_cram_arsize,
   output logic [1:0]  s_cram_arburst,
   output logic        s_cram_arlock,
   output logic [3:0]  s_cram_arcache,
   output logic [2:0]  s_cram_arprot,
   output logic [3:0]  s_cram_arqos,
   output logic        s_cram_arvalid,
   input  logic        s_cram_arready,
   output logic        s_cram_rready,
   input  logic [3:0]  s_cram_rid,
   input  logic [31:0] s_cram_rdata,
   input  logic [1:0]  s_cram_rresp,
   input  logic        s_cram_rlast,
   input  logic        s_cram_rvalid,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_error
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam logic [1:0]  RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      ERR   = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   state_e         state_q, state_d;
   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [31:0]    resp_pc_q, resp_pc_d;
   logic [CW-1:0]  outstanding_q, outstanding_d;
   logic [CW-1:0]  occupancy_q, occupancy_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic           arvalid_q, arvalid_d;
   logic [31:0]    araddr_q, araddr_d;
   logic           rready_q, rready_d;
   logic           fetch_error_q, fetch_error_d;
   entry_t         buf_q [FIFO_DEPTH];

   logic           ar_hs;
   logic           r_hs;
   logic           pop;
   logic           push;
   logic           ar_pending;
   logic           unused_inputs;

   assign unused_inputs = ^{s_cram_rid, s_cram_rlast, redirect_pc[1:0]};

   assign s_cram_arid    = 4'd0;
   assign s_cram_arlen   = 8'd0;
   assign s_cram_arsize  = 3'b010;
   assign s_cram_arburst = 2'b01;
   assign s_cram_arlock  = 1'b0;
   assign s_cram_arcache = 4'd0;
   assign s_cram_arprot  = 3'd0;
   assign s_cram_arqos   = 4'd0;

   assign s_cram_arvalid = arvalid_q;
   assign s_cram_araddr  = araddr_q;
   assign s_cram_rready  = rready_q;
   assign fetch_error    = fetch_error_q;
   assign instr_valid    = (occupancy_q != '0);
   assign instr          = buf_q[rd_ptr_q].data;
   assign instr_pc       = buf_q[rd_ptr_q].pc;

   assign ar_hs      = arvalid_q && s_cram_arready;
   assign r_hs       = s_cram_rvalid && rready_q;
   assign pop        = instr_valid && instr_ready;
   assign ar_pending = arvalid_q && !s_cram_arready;

   // Next-state, credit accounting and request generation
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      occupancy_d   = occupancy_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      rready_d      = 1'b1;
      fetch_error_d = fetch_error_q;
      push          = 1'b0;

      if (ar_hs) begin
         outstanding_d = outstanding_d + CW'(1);
         arvalid_d     = 1'b0;
         // Only live requests advance the fetch address; stale ones are drained
         if (state_q == FETCH) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
      end
      if (r_hs) begin
         outstanding_d = outstanding_d - CW'(1);
      end

      case (state_q)
         FETCH: begin
            if (r_hs) begin
               if (s_cram_rresp == RESP_OKAY) begin
                  push = 1'b1;
               end else begin
                  fetch_error_d = 1'b1;
                  state_d       = ERR;
               end
            end
         end
         DRAIN: begin
            if ((outstanding_q == '0) && !arvalid_q) begin
               state_d = FETCH;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      if (push) begin
         wr_ptr_d    = wr_ptr_q + AW'(1);
         resp_pc_d   = resp_pc_q + 32'd4;
         occupancy_d = occupancy_d + CW'(1);
      end
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + AW'(1);
         occupancy_d = occupancy_d - CW'(1);
      end

      // Redirect flushes everything; a still-pending AR must drain as stale
      if (redirect_valid) begin
         push          = 1'b0;
         occupancy_d   = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         fetch_pc_d    = {redirect_pc[31:2], 2'b00};
         resp_pc_d     = {redirect_pc[31:2], 2'b00};
         fetch_error_d = 1'b0;
         state_d       = ((outstanding_d != '0) || ar_pending) ? DRAIN : FETCH;
      end

      if (!arvalid_d && (state_d == FETCH) &&
          ((SW'(outstanding_d) + SW'(occupancy_d)) < SW'(FIFO_DEPTH))) begin
         arvalid_d = 1'b1;
         araddr_d  = fetch_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= FETCH;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         occupancy_q   <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         arvalid_q     <= 1'b0;
         araddr_q      <= RESET_PC;
         rready_q      <= 1'b0;
         fetch_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         occupancy_q   <= occupancy_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         rready_q      <= rready_d;
         fetch_error_q <= fetch_error_d;
      end
   end

   // Instruction buffer storage, no reset needed
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         buf_q[wr_ptr_q] <= '{pc: resp_pc_q, data: s_cram_rdata};
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency code RAM responder.
module tb_instr_fetch_unit;

   localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst;
   logic [3:0]  s_cram_arid;
   logic [31:0] s_cram_araddr;
   logic [7:0]  s_cram_arlen;
   logic [2:0]  s_cram_arsize;
   logic [1:0]  s_cram_arburst;
   logic        s_cram_arlock;
   logic [3:0]  s_cram_arcache;
   logic [2:0]  s_cram_arprot;
   logic [3:0]  s_cram_arqos;
   logic        s_cram_arvalid;
   logic        s_cram_arready;
   logic        s_cram_rready;
   logic [3:0]  s_cram_rid;
   logic [31:0] s_cram_rdata;
   logic [1:0]  s_cram_rresp;
   logic        s_cram_rlast;
   logic        s_cram_rvalid;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_error;

   int          n_checks;
   int          n_errors;
   int          resp_budget;
   logic [31:0] err_addr;
   logic [31:0] pend[$];
   logic [31:0] ar_log[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_instr[$];

   logic        sv_ar, sv_r, sv_pop, sv_rst;
   logic [31:0] sv_addr, sv_pc, sv_instr;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .s_cram_arid    (s_cram_arid),
      .s_cram_araddr  (s_cram_araddr),
      .s_cram_arlen   (s_cram_arlen),
      .s_cram_arsize  (s_cram_arsize),
      .s_cram_arburst (s_cram_arburst),
      .s_cram_arlock  (s_cram_arlock),
      .s_cram_arcache (s_cram_arcache),
      .s_cram_arprot  (s_cram_arprot),
      .s_cram_arqos   (s_cram_arqos),
      .s_cram_arvalid (s_cram_arvalid),
      .s_cram_arready (s_cram_arready),
      .s_cram_rready  (s_cram_rready),
      .s_cram_rid     (s_cram_rid),
      .s_cram_rdata   (s_cram_rdata),
      .s_cram_rresp   (s_cram_rresp),
      .s_cram_rlast   (s_cram_rlast),
      .s_cram_rvalid  (s_cram_rvalid),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_error    (fetch_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ (a >> 2);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory responder and transaction monitor
   always @(posedge clk) begin
      sv_rst   = rst;
      sv_ar    = s_cram_arvalid && s_cram_arready;
      sv_addr  = s_cram_araddr;
      sv_r     = s_cram_rvalid && s_cram_rready;
      sv_pop   = instr_valid && instr_ready;
      sv_pc    = instr_pc;
      sv_instr = instr;
      #1;
      if (sv_rst) begin
         pend.delete();
         s_cram_rvalid = 1'b0;
      end else begin
         if (sv_pop) begin
            pop_pc.push_back(sv_pc);
            pop_instr.push_back(sv_instr);
         end
         if (sv_r && pend.size() > 0) begin
            void'(pend.pop_front());
            if (resp_budget > 0) resp_budget--;
         end
         if (sv_ar) begin
            pend.push_back(sv_addr);
            ar_log.push_back(sv_addr);
         end
         if (pend.size() > 0 && resp_budget != 0) begin
            s_cram_rvalid = 1'b1;
            s_cram_rdata  = mem_word(pend[0]);
            s_cram_rresp  = (pend[0] == err_addr) ? 2'b10 : 2'b00;
         end else begin
            s_cram_rvalid = 1'b0;
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      repeat (3) @(negedge clk);
      ar_log.delete();
      pop_pc.delete();
      pop_instr.delete();
      rst = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   task automatic wait_ar(input int n);
      int k;
      k = 0;
      while (ar_log.size() < n && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_eq("wait_ar", 32'(ar_log.size() >= n), 32'd1);
   endtask

   initial begin
      int gaps;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      s_cram_arready = 1'b1;
      s_cram_rid = 4'd0;
      s_cram_rdata = 32'd0;
      s_cram_rresp = 2'b00;
      s_cram_rlast = 1'b1;
      s_cram_rvalid = 1'b0;
      instr_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      resp_budget = -1;
      err_addr = NO_ERR;

      // Reset values
      apply_reset();
      rst = 1'b1;
      check_eq("rst_arvalid", 32'(s_cram_arvalid), 32'd0);
      check_eq("rst_rready", 32'(s_cram_rready), 32'd0);
      check_eq("rst_ivalid", 32'(instr_valid), 32'd0);
      check_eq("rst_ferr", 32'(fetch_error), 32'd0);
      check_eq("rst_araddr", s_cram_araddr, 32'h0);
      check_eq("arsize", 32'(s_cram_arsize), 32'd2);
      check_eq("arburst", 32'(s_cram_arburst), 32'd1);

      // Streaming fetch, no gaps
      rst = 1'b0;
      @(negedge clk);
      check_eq("first_ar_valid", 32'(s_cram_arvalid), 32'd1);
      check_eq("first_ar_addr", s_cram_araddr, 32'h0);
      repeat (5) @(negedge clk);
      gaps = 0;
      for (int i = 0; i < 10; i++) begin
         if (!instr_valid) gaps++;
         @(negedge clk);
      end
      check_eq("stream_gaps", 32'(gaps), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_eq("stream_ar", ar_log[i], 32'(4 * i));
         check_eq("stream_pc", pop_pc[i], 32'(4 * i));
         check_eq("stream_instr", pop_instr[i], mem_word(32'(4 * i)));
      end

      // Back-pressure: credit limit of four
      instr_ready = 1'b0;
      apply_reset();
      repeat (15) @(negedge clk);
      check_eq("bp_ar_count", 32'(ar_log.size()), 32'd4);
      check_eq("bp_ar3", ar_log[3], 32'hC);
      check_eq("bp_ivalid", 32'(instr_valid), 32'd1);
      check_eq("bp_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("bp_ar_count2", 32'(ar_log.size()), 32'd5);
      check_eq("bp_ar4", ar_log[4], 32'h10);
      check_eq("bp_pc2", instr_pc, 32'h4);

      // Redirect with three reads outstanding
      resp_budget = 1;
      apply_reset();
      wait_ar(4);
      repeat (3) @(negedge clk);
      check_eq("rd_ar_count", 32'(ar_log.size()), 32'd4);
      check_eq("rd_arvalid", 32'(s_cram_arvalid), 32'd0);
      check_eq("rd_pc0", instr_pc, 32'h0);
      pulse_redirect(32'h103);
      check_eq("rd_flush", 32'(instr_valid), 32'd0);
      check_eq("rd_drain_noar", 32'(s_cram_arvalid), 32'd0);
      resp_budget = -1;
      instr_ready = 1'b1;
      repeat (12) @(negedge clk);
      check_eq("rd_ar_next", ar_log[4], 32'h100);
      check_eq("rd_pop_nonempty", 32'(pop_pc.size() > 0), 32'd1);
      check_eq("rd_pop_pc", pop_pc[0], 32'h100);
      check_eq("rd_pop_instr", pop_instr[0], mem_word(32'h100));

      // Bus error on 0x8
      instr_ready = 1'b0;
      err_addr = 32'h8;
      apply_reset();
      repeat (12) @(negedge clk);
      check_eq("err_flag", 32'(fetch_error), 32'd1);
      check_eq("err_ar_count", 32'(ar_log.size()), 32'd4);
      check_eq("err_arvalid", 32'(s_cram_arvalid), 32'd0);
      check_eq("err_head_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("err_pop_count", 32'(pop_pc.size()), 32'd2);
      check_eq("err_pop_pc1", pop_pc[1], 32'h4);
      check_eq("err_pop_instr1", pop_instr[1], mem_word(32'h4));
      check_eq("err_empty", 32'(instr_valid), 32'd0);
      err_addr = NO_ERR;
      pulse_redirect(32'h40);
      check_eq("err_cleared", 32'(fetch_error), 32'd0);
      repeat (8) @(negedge clk);
      check_eq("err_resume_ar", ar_log[4], 32'h40);
      check_eq("err_resume_pc", pop_pc[2], 32'h40);

      // Redirect while AR stalled
      s_cram_arready = 1'b0;
      apply_reset();
      repeat (3) @(negedge clk);
      check_eq("stall_arvalid", 32'(s_cram_arvalid), 32'd1);
      pulse_redirect(32'h200);
      check_eq("stall_hold_v", 32'(s_cram_arvalid), 32'd1);
      check_eq("stall_hold_a", s_cram_araddr, 32'h0);
      repeat (2) @(negedge clk);
      check_eq("stall_hold_a2", s_cram_araddr, 32'h0);
      s_cram_arready = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("stall_ar0", ar_log[0], 32'h0);
      check_eq("stall_ar1", ar_log[1], 32'h200);
      check_eq("stall_pop_pc", pop_pc[0], 32'h200);

      // Reset with reads in flight
      instr_ready = 1'b0;
      resp_budget = 0;
      apply_reset();
      wait_ar(2);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_arvalid", 32'(s_cram_arvalid), 32'd0);
      check_eq("mid_rst_rready", 32'(s_cram_rready), 32'd0);
      check_eq("mid_rst_ivalid", 32'(instr_valid), 32'd0);
      check_eq("mid_rst_araddr", s_cram_araddr, 32'h0);
      ar_log.delete();
      pop_pc.delete();
      pop_instr.delete();
      resp_budget = -1;
      instr_ready = 1'b1;
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("mid_rst_ar0", ar_log[0], 32'h0);
      check_eq("mid_rst_pop_nonempty", 32'(pop_pc.size() > 0), 32'd1);
      check_eq("mid_rst_pop_pc", pop_pc[0], 32'h0);
      check_eq("mid_rst_pop_instr", pop_instr[0], mem_word(32'h0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (word-aligned).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning instruction buffer entries and maximum in-flight reads (power of 2, 2..16).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_cram_arid  out  4  constant 0.
- s_cram_araddr  out  32  fetch byte address.
- s_cram_arlen  out  8  constant 0.
- s_cram_arsize  out  3  constant 3'b010.
- s_cram_arburst  out  2  constant 2'b01.
- s_cram_arlock/arcache/arprot/arqos  out  1/4/3/4  constant 0.
- s_cram_arvalid  out  1  AR request.
- s_cram_arready  in  1  AR accept.
- s_cram_rready  out  1  R accept.
- s_cram_rid  in  4  ignored.
- s_cram_rdata  in  32  instruction word.
- s_cram_rresp  in  2  response code.
- s_cram_rlast  in  1  ignored (single beat).
- s_cram_rvalid  in  1  R valid.
- instr_valid  out  1  buffer head valid.
- instr  out  32  head instruction.
- instr_pc  out  32  head PC.
- instr_ready  in  1  consumer pop.
- redirect_valid  in  1  branch/jump redirect pulse.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0.
- fetch_error  out  1  sticky bus-error flag.

Function
REQ-004 SHALL keep three states: FETCH, DRAIN, ERR; reset state FETCH.
REQ-005 SHALL maintain fetch_pc (next AR address), resp_pc (PC of next accepted response), outstanding (AR accepted minus R accepted, 0..FIFO_DEPTH), occupancy (0..FIFO_DEPTH).
REQ-006 SHALL in FETCH with arvalid=0 assert arvalid next cycle when outstanding + occupancy < FIFO_DEPTH, driving araddr=fetch_pc.
REQ-007 SHALL hold arvalid and araddr stable until arready, regardless of redirect or state change.
REQ-008 SHALL on AR handshake increment outstanding and fetch_pc by 4 (32-bit wrap); back-to-back AR every cycle permitted.
REQ-009 SHALL keep s_cram_rready=1 in every non-reset cycle; credit rule of REQ-006 guarantees buffer space.
REQ-010 SHALL in FETCH on R handshake with rresp=OKAY push {rdata, resp_pc} and increment resp_pc by 4; push and pop in same cycle leave occupancy unchanged.
REQ-011 SHALL on R handshake with rresp!=OKAY discard the data, set fetch_error=1, enter ERR; ERR issues no new AR and discards further responses; buffered entries remain poppable.
REQ-012 SHALL drive instr_valid=(occupancy!=0), instr/instr_pc from buffer head; pop when instr_valid&&instr_ready.
REQ-013 SHALL on redirect_valid (any state): flush buffer (occupancy=0, overrides same-cycle push/pop), set fetch_pc=resp_pc=redirect_pc&~3, clear fetch_error, enter DRAIN if outstanding after this cycle's handshakes (incl. an AR handshake this cycle) >0, else FETCH.
REQ-014 SHALL in DRAIN issue no new AR (a pending arvalid completes per REQ-007 and counts as stale), discard all responses, and return to FETCH the cycle after outstanding reaches 0.
REQ-015 SHALL count discarded responses in outstanding like accepted ones.
REQ-016 SHALL give 1-cycle latency from R handshake to instr_valid; first AR 1 cycle after rst deasserts.

Reset
REQ-017 SHALL with rst=1 at a clock edge set: state=FETCH, arvalid=0, rready=0, instr_valid=0, fetch_error=0, outstanding=0, occupancy=0, fetch_pc=resp_pc=RESET_PC, araddr=RESET_PC; reset mid-transaction abandons all in-flight reads without tracking.

Verification
REQ-018 Reset release, arready=1, rdata=i-th word, rvalid 1 cycle after AR, instr_ready=1 -> AR addrs 0,4,8,...; instr_pc 0,4,8 with matching instr, no gaps.
REQ-019 instr_ready=0, memory always responds -> exactly 4 ARs (0..C), instr_valid held, no 5th AR until one pop; then AR 0x10.
REQ-020 3 reads outstanding, redirect_pc=0x103 -> buffer empties next cycle, 3 responses discarded, no AR during DRAIN, then AR 0x100, first instr_pc=0x100.
REQ-021 rresp=2'b10 on read of 0x8 -> entries 0x0,0x4 still delivered, fetch_error=1, no further AR; redirect to 0x40 -> fetch_error=0, fetching resumes at 0x40.
REQ-022 arready=0 with arvalid high and redirect pulsed -> araddr unchanged until arready, that response discarded, next AR=redirect_pc.
REQ-023 rst asserted with 2 reads in flight -> all outputs at reset values next cycle, next AR=RESET_PC.
